// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file
//
// Machine-mode CSR register file with 64-bit mcycle/minstret counters and
// trap/mret state handling. It sits right after the instruction decoder. It
// returns the old CSR value for rd writeback and flags illegal CSR accesses.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   csr_adr           : CSR address (inst[31:20])
//   csr_op_ctr        : 0=write, 1=set, 2=clear, 3=no CSR op
//   csr_imm_en        : operand is zero-extended csr_src instead of rs1_data
//   csr_read_en       : qualifies csr_rdata
//   csr_src           : zimm / rs1 index (used for the x0 "no write" rule)
//   rs1_data          : rs1 register value
//   csr_rdata         : old CSR value (combinational), 0 if unqualified/unmapped
//   illegal_csr       : unmapped address or write attempt to a read-only CSR
//   inst_retire       : one instruction retires this cycle
//   trap_en, trap_pc, trap_cause, trap_val : trap entry request and its data
//   mret              : return from trap
//   mtvec_out, mepc_out, mie_global : current mtvec, mepc, mstatus.MIE
// ---------------------------------------------------------------------------
module csr_file #(
    parameter logic [31:0] HART_ID  = 32'd0,
    parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_adr,
    input  logic [1:0]  csr_op_ctr,
    input  logic        csr_imm_en,
    input  logic        csr_read_en,
    input  logic [4:0]  csr_src,
    input  logic [31:0] rs1_data,
    output logic [31:0] csr_rdata,
    output logic        illegal_csr,
    input  logic        inst_retire,
    input  logic        trap_en,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_val,
    input  logic        mret,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        mie_global
);

    localparam logic [11:0] ADR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADR_MISA      = 12'h301;
    localparam logic [11:0] ADR_MIE       = 12'h304;
    localparam logic [11:0] ADR_MTVEC     = 12'h305;
    localparam logic [11:0] ADR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADR_MEPC      = 12'h341;
    localparam logic [11:0] ADR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADR_MTVAL     = 12'h343;
    localparam logic [11:0] ADR_MIP       = 12'h344;
    localparam logic [11:0] ADR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADR_INSTRETH  = 12'hC82;
    localparam logic [11:0] ADR_MHARTID   = 12'hF14;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_SET   = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_NONE  = 2'd3;

    // Architectural state
    logic        mstatus_mie_reg;
    logic        mstatus_mpie_reg;
    logic [31:0] mie_reg;
    logic [31:0] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic [31:0] mtval_reg;

    // Counter values: index 0 = mcycle, index 1 = minstret
    logic [1:0][63:0] cnt_val;

    logic [31:0] old_val;
    logic        adr_mapped;
    logic        adr_read_only;
    logic [31:0] operand;
    logic [31:0] wdata;
    logic        write_req;
    logic        write_en;

    // Address decode and old-value mux
    always_comb begin
        old_val    = '0;
        adr_mapped = 1'b1;
        case (csr_adr)
            ADR_MSTATUS:   old_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};
            ADR_MISA:      old_val = MISA_VAL;
            ADR_MIE:       old_val = mie_reg;
            ADR_MTVEC:     old_val = mtvec_reg;
            ADR_MSCRATCH:  old_val = mscratch_reg;
            ADR_MEPC:      old_val = mepc_reg;
            ADR_MCAUSE:    old_val = mcause_reg;
            ADR_MTVAL:     old_val = mtval_reg;
            ADR_MIP:       old_val = '0;
            ADR_MCYCLE,
            ADR_CYCLE:     old_val = cnt_val[0][31:0];
            ADR_MCYCLEH,
            ADR_CYCLEH:    old_val = cnt_val[0][63:32];
            ADR_MINSTRET,
            ADR_INSTRET:   old_val = cnt_val[1][31:0];
            ADR_MINSTRETH,
            ADR_INSTRETH:  old_val = cnt_val[1][63:32];
            ADR_MHARTID:   old_val = HART_ID;
            default:       adr_mapped = 1'b0;
        endcase
    end

    // 0xCxx and 0xFxx are the read-only user counters and machine info CSRs
    assign adr_read_only = (csr_adr[11:10] == 2'b11);

    assign operand = csr_imm_en ? {27'b0, csr_src} : rs1_data;

    // Set/clear with x0 (or zimm 0) is a pure read and must not count as a write
    assign write_req = (csr_op_ctr == OP_WRITE) ||
                       (((csr_op_ctr == OP_SET) || (csr_op_ctr == OP_CLEAR)) && (csr_src != 5'd0));

    assign illegal_csr = (csr_op_ctr != OP_NONE) &&
                         (!adr_mapped || (adr_read_only && write_req));

    assign write_en = write_req && !illegal_csr && !trap_en;

    always_comb begin
        case (csr_op_ctr)
            OP_SET:   wdata = old_val | operand;
            OP_CLEAR: wdata = old_val & ~operand;
            default:  wdata = operand;
        endcase
    end

    assign csr_rdata = (csr_read_en && adr_mapped) ? old_val : '0;

    // 64-bit counters. A write to either half replaces that half and
    // suppresses the whole counter's increment for the cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            localparam logic [11:0] ADR_LO = ADR_MCYCLE  + 12'(2 * gi);
            localparam logic [11:0] ADR_HI = ADR_MCYCLEH + 12'(2 * gi);
            localparam bit          FREE_RUN = (gi == 0);

            logic [63:0] cnt_reg;
            logic        cnt_inc;

            assign cnt_inc = FREE_RUN ? 1'b1 : inst_retire;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (write_en && (csr_adr == ADR_LO)) begin
                    cnt_reg <= {cnt_reg[63:32], wdata};
                end else if (write_en && (csr_adr == ADR_HI)) begin
                    cnt_reg <= {wdata, cnt_reg[31:0]};
                end else if (cnt_inc) begin
                    cnt_reg <= cnt_reg + 64'd1;
                end
            end

            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    // Trap, mret and CSR write handling. Trap beats mret beats a CSR write
    // for mstatus; the other CSRs only see CSR writes or trap entry, and
    // write_en is already low during a trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_reg          <= '0;
            mtvec_reg        <= '0;
            mscratch_reg     <= '0;
            mepc_reg         <= '0;
            mcause_reg       <= '0;
            mtval_reg        <= '0;
        end else begin
            if (trap_en) begin
                mstatus_mpie_reg <= mstatus_mie_reg;
                mstatus_mie_reg  <= 1'b0;
                mepc_reg         <= trap_pc & ~32'd3;
                mcause_reg       <= trap_cause;
                mtval_reg        <= trap_val;
            end else if (mret) begin
                mstatus_mie_reg  <= mstatus_mpie_reg;
                mstatus_mpie_reg <= 1'b1;
            end else if (write_en && (csr_adr == ADR_MSTATUS)) begin
                mstatus_mie_reg  <= wdata[3];
                mstatus_mpie_reg <= wdata[7];
            end

            if (write_en) begin
                case (csr_adr)
                    ADR_MIE:      mie_reg      <= wdata;
                    ADR_MTVEC:    mtvec_reg    <= wdata & ~32'd3;
                    ADR_MSCRATCH: mscratch_reg <= wdata;
                    ADR_MEPC:     mepc_reg     <= wdata & ~32'd3;
                    ADR_MCAUSE:   mcause_reg   <= wdata;
                    ADR_MTVAL:    mtval_reg    <= wdata;
                    default:      ;
                endcase
            end
        end
    end

    assign mtvec_out  = mtvec_reg;
    assign mepc_out   = mepc_reg;
    assign mie_global = mstatus_mie_reg;

endmodule

// File: tb/tb_csr_file.sv
// ---------------------------------------------------------------------------
// tb_csr_file
//
// Self-checking bench for csr_file: directed scenarios followed by random
// traffic, all compared against a behavioural model that keeps the CSRs in
// an associative array and the counters as 64-bit integers.
// ---------------------------------------------------------------------------
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] csr_adr;
    logic [1:0]  csr_op_ctr;
    logic        csr_imm_en;
    logic        csr_read_en;
    logic [4:0]  csr_src;
    logic [31:0] rs1_data;
    logic [31:0] csr_rdata;
    logic        illegal_csr;
    logic        inst_retire;
    logic        trap_en;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_val;
    logic        mret;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mie_global;

    csr_file dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .csr_adr     (csr_adr),
        .csr_op_ctr  (csr_op_ctr),
        .csr_imm_en  (csr_imm_en),
        .csr_read_en (csr_read_en),
        .csr_src     (csr_src),
        .rs1_data    (rs1_data),
        .csr_rdata   (csr_rdata),
        .illegal_csr (illegal_csr),
        .inst_retire (inst_retire),
        .trap_en     (trap_en),
        .trap_pc     (trap_pc),
        .trap_cause  (trap_cause),
        .trap_val    (trap_val),
        .mret        (mret),
        .mtvec_out   (mtvec_out),
        .mepc_out    (mepc_out),
        .mie_global  (mie_global)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]     m_reg [logic [11:0]];
    longint unsigned m_cnt [2];
    bit              m_mie;
    bit              m_mpie;

    task automatic model_reset();
        m_reg[12'h304] = '0;
        m_reg[12'h305] = '0;
        m_reg[12'h340] = '0;
        m_reg[12'h341] = '0;
        m_reg[12'h342] = '0;
        m_reg[12'h343] = '0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_mie  = 1'b0;
        m_mpie = 1'b0;
    endtask

    function automatic void model_read(input logic [11:0] a, output logic [31:0] v,
                                       output bit mapped, output bit ro);
        longint unsigned c0, c1;
        c0 = m_cnt[0];
        c1 = m_cnt[1];
        v = '0;
        mapped = 1'b1;
        ro = 1'b0;
        case (a)
            12'h300: v = 32'h0000_1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h301: v = 32'h4000_0100;
            12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343: v = m_reg[a];
            12'h344: v = '0;
            12'hB00: v = c0[31:0];
            12'hB80: v = c0[63:32];
            12'hB02: v = c1[31:0];
            12'hB82: v = c1[63:32];
            12'hC00: begin v = c0[31:0];  ro = 1'b1; end
            12'hC80: begin v = c0[63:32]; ro = 1'b1; end
            12'hC02: begin v = c1[31:0];  ro = 1'b1; end
            12'hC82: begin v = c1[63:32]; ro = 1'b1; end
            12'hF14: begin v = '0;        ro = 1'b1; end
            default: mapped = 1'b0;
        endcase
    endfunction

    // One clock cycle: check combinational/registered outputs against the
    // model, let the edge happen, then advance the model.
    task automatic step();
        logic [31:0] old_v, opnd, wv, exp_rd;
        bit mapped, ro, writes, ill, we;
        logic [11:0] a;
        logic [1:0]  op;
        bit t, r, ret;
        logic [31:0] tpc, tcause, tval;
        longint unsigned lo_adr, hi_adr;
        #1;
        a = csr_adr; op = csr_op_ctr; t = trap_en; r = mret; ret = inst_retire;
        tpc = trap_pc; tcause = trap_cause; tval = trap_val;
        model_read(a, old_v, mapped, ro);
        exp_rd = (csr_read_en && mapped) ? old_v : 32'd0;
        writes = (op == 2'd0) || ((op == 2'd1 || op == 2'd2) && csr_src != 5'd0);
        ill = (op != 2'd3) && (!mapped || (ro && writes));
        check("rdata", csr_rdata, exp_rd);
        check("illegal", illegal_csr, ill);
        check("mtvec_out", mtvec_out, m_reg[12'h305]);
        check("mepc_out", mepc_out, m_reg[12'h341]);
        check("mie_global", mie_global, m_mie);
        $display("cyc adr=%h op=%0d src=%0d rs1=%h rd=%h ill=%0b trap=%0b mret=%0b ret=%0b",
                 a, op, csr_src, rs1_data, csr_rdata, illegal_csr, t, r, ret);
        we = writes && !ill && !t;
        opnd = csr_imm_en ? {27'b0, csr_src} : rs1_data;
        if (op == 2'd1)      wv = old_v | opnd;
        else if (op == 2'd2) wv = old_v & ~opnd;
        else                 wv = opnd;

        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            lo_adr = (i == 0) ? 64'hB00 : 64'hB02;
            hi_adr = (i == 0) ? 64'hB80 : 64'hB82;
            if (we && 64'(a) == lo_adr)
                m_cnt[i] = {m_cnt[i][63:32], wv};
            else if (we && 64'(a) == hi_adr)
                m_cnt[i] = {wv, m_cnt[i][31:0]};
            else if (i == 0 || ret)
                m_cnt[i] = m_cnt[i] + 1;
        end
        if (t) begin
            m_reg[12'h341] = tpc & ~32'd3;
            m_reg[12'h342] = tcause;
            m_reg[12'h343] = tval;
            m_mpie = m_mie;
            m_mie  = 1'b0;
        end else if (r) begin
            m_mie  = m_mpie;
            m_mpie = 1'b1;
        end
        if (we) begin
            case (a)
                12'h300: if (!r) begin m_mie = wv[3]; m_mpie = wv[7]; end
                12'h304, 12'h340, 12'h342, 12'h343: m_reg[a] = wv;
                12'h305, 12'h341: m_reg[a] = wv & ~32'd3;
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        csr_adr = '0; csr_op_ctr = 2'd3; csr_imm_en = 1'b0; csr_read_en = 1'b0;
        csr_src = '0; rs1_data = '0; inst_retire = 1'b0; trap_en = 1'b0;
        trap_pc = '0; trap_cause = '0; trap_val = '0; mret = 1'b0;
    endtask

    task automatic set_csr(input logic [1:0] op, input logic [11:0] adr, input bit imm,
                           input logic [4:0] src, input logic [31:0] rs1);
        idle();
        csr_op_ctr = op; csr_adr = adr; csr_imm_en = imm; csr_src = src;
        rs1_data = rs1; csr_read_en = 1'b1;
    endtask

    task automatic expect_read(input string tag, input logic [11:0] adr, input logic [31:0] exp);
        idle();
        csr_adr = adr; csr_read_en = 1'b1;
        #1 check(tag, csr_rdata, exp);
        step();
    endtask

    task automatic do_reset();
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mtvec", mtvec_out, 32'd0);
        check("async_rst_mepc", mepc_out, 32'd0);
        check("async_rst_mie", mie_global, 1'b0);
        csr_adr = 12'h340; csr_read_en = 1'b1;
        #1 check("async_rst_mscratch", csr_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle();
    endtask

    logic [11:0] pool [21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                               12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                               12'hC02, 12'hC80, 12'hC82, 12'hF14, 12'h7C0, 12'h123, 12'hFFF};

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        csr_adr = 12'h300; csr_read_en = 1'b1;
        #1;
        check("rst_mtvec", mtvec_out, 32'd0);
        check("rst_mepc", mepc_out, 32'd0);
        check("rst_mie", mie_global, 1'b0);
        check("rst_mstatus", csr_rdata, 32'h0000_1800);
        csr_adr = 12'hB00;
        #1 check("rst_mcycle", csr_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle();

        // csrrw returns the old value, new value visible next cycle
        set_csr(2'd0, 12'h340, 1'b0, 5'd1, 32'hDEAD_BEEF);
        #1 check("csrrw_old", csr_rdata, 32'd0);
        step();
        expect_read("mscratch_rw", 12'h340, 32'hDEAD_BEEF);

        // set / clear / set-with-x0
        set_csr(2'd0, 12'h340, 1'b0, 5'd1, 32'hF0F0_F0F0); step();
        set_csr(2'd1, 12'h340, 1'b0, 5'd5, 32'h0000_000F); step();
        expect_read("csrrs", 12'h340, 32'hF0F0_F0FF);
        set_csr(2'd2, 12'h340, 1'b1, 5'h1F, 32'd0); step();
        expect_read("csrrc_imm", 12'h340, 32'hF0F0_F0E0);
        set_csr(2'd1, 12'h340, 1'b0, 5'd0, 32'hFFFF_FFFF); step();
        expect_read("csrrs_x0", 12'h340, 32'hF0F0_F0E0);

        // mcycle carry into mcycleh
        set_csr(2'd0, 12'hB00, 1'b0, 5'd1, 32'hFFFF_FFFF); step();
        idle(); step();
        expect_read("mcycle_wrap", 12'hB00, 32'd0);
        expect_read("mcycleh_carry", 12'hB80, 32'd1);

        // counter write beats increment
        set_csr(2'd0, 12'hB02, 1'b0, 5'd1, 32'd5);
        inst_retire = 1'b1;
        step();
        expect_read("minstret_wr_wins", 12'hB02, 32'd5);

        // trap entry and mret
        set_csr(2'd1, 12'h300, 1'b1, 5'd8, 32'd0); step();
        idle();
        trap_en = 1'b1; trap_pc = 32'h0000_1003; trap_cause = 32'd2; trap_val = 32'h55;
        step();
        idle();
        #1;
        check("trap_mepc", mepc_out, 32'h0000_1000);
        check("trap_mie", mie_global, 1'b0);
        step();
        expect_read("trap_mcause", 12'h342, 32'd2);
        expect_read("trap_mstatus", 12'h300, 32'h0000_1880);
        idle(); mret = 1'b1; step();
        idle();
        #1 check("mret_mie", mie_global, 1'b1);
        step();

        // illegal accesses
        set_csr(2'd0, 12'hC00, 1'b0, 5'd1, 32'h123);
        #1 check("ill_ro_write", illegal_csr, 1'b1);
        step();
        set_csr(2'd0, 12'h7C0, 1'b0, 5'd1, 32'h123);
        #1 check("ill_unmapped", illegal_csr, 1'b1);
        step();
        set_csr(2'd1, 12'hC00, 1'b0, 5'd0, 32'hFFFF_FFFF);
        #1;
        check("ro_read_legal", illegal_csr, 1'b0);
        check("ro_read_cycle", csr_rdata, m_cnt[0] & 64'hFFFF_FFFF);
        step();
        expect_read("state_after_ill", 12'h340, 32'hF0F0_F0E0);

        // mtvec masking, then a trap blocks a simultaneous mtvec write
        set_csr(2'd0, 12'h305, 1'b0, 5'd1, 32'h0000_0083); step();
        expect_read("mtvec_mask", 12'h305, 32'h0000_0080);
        set_csr(2'd0, 12'h305, 1'b0, 5'd1, 32'h0000_0200);
        trap_en = 1'b1; trap_pc = 32'h0000_2222; trap_cause = 32'd7;
        step();
        idle();
        #1;
        check("trap_blocks_write", mtvec_out, 32'h0000_0080);
        check("trap_mepc2", mepc_out, 32'h0000_2220);
        step();

        // mret wins over a simultaneous mstatus write
        set_csr(2'd0, 12'h300, 1'b0, 5'd1, 32'd0);
        mret = 1'b1;
        step();
        idle();
        #1 check("mret_over_write", mie_global, 1'b1);
        step();

        // random traffic with a mid-run asynchronous reset
        for (int n = 0; n < 600; n++) begin
            idle();
            csr_adr     = pool[$urandom_range(0, 20)];
            csr_op_ctr  = 2'($urandom_range(0, 3));
            csr_imm_en  = 1'($urandom_range(0, 1));
            csr_read_en = 1'($urandom_range(0, 1));
            csr_src     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            rs1_data    = $urandom;
            inst_retire = 1'($urandom_range(0, 1));
            trap_en     = ($urandom_range(0, 19) == 0);
            mret        = ($urandom_range(0, 9) == 0);
            trap_pc     = $urandom;
            trap_cause  = $urandom;
            trap_val    = $urandom;
            step();
            if (n == 300) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file and counter block, directly downstream of the instruction decoder.
- Consumes the decoder's CSR controls (csr_op_ctr, csr_imm_en, csr_read_en), the CSR address field and the rs1/zimm field.
- Returns the old CSR value for rd writeback and holds trap state (mepc, mcause, mtval, mstatus.MIE/MPIE) plus the 64-bit mcycle/minstret counters.

Parameters:
- HART_ID, 0, value returned by mhartid (0xF14).
- MISA_VAL, 32'h40000100, value returned by misa (0x301) (RV32I); writes to misa are ignored.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- csr_adr  input  12  CSR address, inst[31:20].
- csr_op_ctr  input  2  0=write, 1=set, 2=clear, 3=no CSR op.
- csr_imm_en  input  1  1: operand = zero-extended csr_src; 0: operand = rs1_data.
- csr_read_en  input  1  qualifies csr_rdata.
- csr_src  input  5  inst[19:15]; used as zimm and as the rs1 index for the x0 check.
- rs1_data  input  32  rs1 register value.
- csr_rdata  output  32  old CSR value (combinational); 0 when csr_read_en=0 or address unmapped.
- illegal_csr  output  1  combinational; 1 when csr_op_ctr!=3 and (address unmapped, or a write is attempted to a read-only address).
- inst_retire  input  1  one instruction retires this cycle.
- trap_en  input  1  take trap this cycle.
- trap_pc  input  32  PC of the trapping instruction.
- trap_cause  input  32  mcause value.
- trap_val  input  32  mtval value.
- mret  input  1  mret executes this cycle.
- mtvec_out  output  32  current mtvec.
- mepc_out  output  32  current mepc.
- mie_global  output  1  mstatus.MIE.

Behaviour:
- Reset (async, rst_n=0): all CSR state = 0; mstatus.MPP reads 2'b11 (constant); outputs mtvec_out=0, mepc_out=0, mie_global=0. illegal_csr and csr_rdata follow their combinational definitions.
- Address map:
  - mstatus 0x300: writable bits 3 (MIE) and 7 (MPIE); bits 12:11 read 11; all other bits read 0.
  - misa 0x301; mie 0x304 (full 32 bits); mtvec 0x305 (bits[1:0] forced 0).
  - mscratch 0x340; mepc 0x341 (bits[1:0] forced 0); mcause 0x342; mtval 0x343.
  - mip 0x344: reads 0, writes ignored.
  - mcycle 0xB00 / mcycleh 0xB80; minstret 0xB02 / minstreth 0xB82.
  - Read-only: cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82, mhartid 0xF14.
- Read: combinational from current state; write result is visible from the next cycle.
- Operand: op = csr_imm_en ? {27'b0,csr_src} : rs1_data.
- Write value: op_ctr 0 -> op; op_ctr 1 -> old|op; op_ctr 2 -> old & ~op.
- Write enable: op_ctr==0, or op_ctr in {1,2} with csr_src!=0.
  - Write enable is suppressed when illegal_csr=1 or trap_en=1.
  - Read-only addresses (0xCxx, 0xFxx): illegal only when write enable would be asserted; a pure read is legal.
- Counters:
  - mcycle (64-bit) increments every cycle.
  - minstret (64-bit) increments when inst_retire=1.
  - Increments carry from the low half into the high half; both wrap from all-ones to 0.
  - A CSR write to either half of a counter wins over that cycle's increment of the whole counter. The other half keeps its old value; no carry is applied.
- Trap (trap_en=1), in one cycle:
  - mepc <= trap_pc & ~3; mcause <= trap_cause; mtval <= trap_val.
  - MPIE <= MIE; MIE <= 0.
- mret (trap_en=0): MIE <= MPIE; MPIE <= 1.
- Priority: trap_en > mret > CSR write. If an mret and a CSR write to mstatus occur together, mret wins for mstatus; writes to other CSRs proceed normally.
- Latency: outputs mtvec_out/mepc_out/mie_global reflect updates one cycle after the triggering edge.
- Reset asserted mid-operation clears state immediately (asynchronously).

Test Plan:
- Reset, then csrrw 0x340 with rs1_data=0xDEADBEEF, csr_read_en=1 -> csr_rdata=0 that cycle; next cycle a read of 0x340 returns 0xDEADBEEF.
- mscratch=0xF0F0F0F0:
  - csrrs with rs1_data=0x0F, csr_src=5 -> next read 0xF0F0F0FF.
  - csrrc with zimm 0x1F -> next read 0xF0F0F0E0.
  - csrrs with csr_src=0 -> no write, value unchanged.
- Write mcycle=0xFFFFFFFF, then wait 1 cycle -> mcycle=0, mcycleh=1.
- Counter write vs increment: with inst_retire=1 on the same cycle as a csrrw of minstret=5 -> minstret=5 afterwards.
- MIE=1, trap_en with trap_pc=0x1003, trap_cause=2 ->
  - next cycle: mepc_out=0x1000, mcause=2, mie_global=0, MPIE=1;
  - then mret -> mie_global=1.
- Illegal accesses:
  - csrrw to 0xC00 or 0x7C0 -> illegal_csr=1, state unchanged.
  - csrrs to 0xC00 with csr_src=0 -> illegal_csr=0, returns cycle count.
- trap_en asserted together with a csrrw to 0x305 -> mtvec unchanged, trap state updated.
